// File: rtl/rom_sample_sequencer_if.sv
// rom_sample_sequencer_if: control, config, ROM and sample-stream signals of the sequencer
interface rom_sample_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12,
  parameter int DIV_W  = 16
);
  logic              start;
  logic              stop;
  logic              hold;
  logic [DIV_W-1:0]  cfg_div;
  logic [ADDR_W-1:0] cfg_len;
  logic              cfg_loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              done;
  modport master (
    output start, stop, hold, cfg_div, cfg_len, cfg_loop, rom_data,
    input  rom_addr, sample, sample_valid, busy, done
  );
  modport slave (
    input  start, stop, hold, cfg_div, cfg_len, cfg_loop, rom_data,
    output rom_addr, sample, sample_valid, busy, done
  );
endinterface

// File: rtl/rom_sample_sequencer.sv
// rom_sample_sequencer: paces ROM reads and turns ROM output into a strobed sample stream
module rom_sample_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12,
  parameter int RD_LAT = 2,
  parameter int DIV_W  = 16
) (
  input logic sys_clk,
  input logic sys_rst,
  rom_sample_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state;
  logic [DIV_W-1:0]  div, div_l;
  logic [ADDR_W-1:0] len_l, addr;
  logic              loop_l;
  logic [RD_LAT-1:0] pipe;
  logic [DATA_W-1:0] smp;
  logic              valid, busy, done;
  logic              tick, issue, last;
  assign tick  = state == RUN && !bus.hold && div == div_l;
  assign issue = tick && !bus.stop;
  assign last  = addr == len_l;
  assign bus.rom_addr     = addr;
  assign bus.sample       = smp;
  assign bus.sample_valid = valid;
  assign bus.busy         = busy;
  assign bus.done         = done;
  // pipe tracks outstanding reads so rom_data is captured exactly RD_LAT clocks after issue
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state  <= IDLE;
      div    <= '0;
      div_l  <= '0;
      len_l  <= '0;
      loop_l <= 1'b0;
      addr   <= '0;
      pipe   <= '0;
      smp    <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pipe  <= RD_LAT'({pipe, issue});
      valid <= pipe[RD_LAT-1];
      if (pipe[RD_LAT-1]) smp <= bus.rom_data;
      done  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          div_l  <= bus.cfg_div;
          len_l  <= bus.cfg_len;
          loop_l <= bus.cfg_loop;
          div    <= '0;
          addr   <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: if (bus.stop) state <= DRAIN;
        else if (!bus.hold) begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            addr <= !last ? addr + 1'b1 : loop_l ? '0 : addr;
            if (last && !loop_l) state <= DRAIN;
          end
        end
        DRAIN: if (pipe == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_sample_sequencer.sv
// tb_rom_sample_sequencer: directed and random playback checked against a cycle-indexed event model
module tb_rom_sample_sequencer;
  localparam int AW = 10, DW = 12, RL = 2, DV = 16;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  rom_sample_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(DV)) bus ();
  rom_sample_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .DIV_W(DV)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus)
  );
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rp [RL];
  always_ff @(posedge sys_clk) begin
    rp[0] <= mem[bus.rom_addr];
    for (int k = 1; k < RL; k++) rp[k] <= rp[k-1];
  end
  assign bus.rom_data = rp[RL-1];
  typedef struct {int due; logic [DW-1:0] val;} ev_t;
  ev_t q[$];
  int total = 0, bad = 0, cyc = 0, nval = 0;
  int m_mode = 0, m_div = 0, m_len = 0, active = 0, n = 0, last_due = 0, done_at = -1, m_addr = 0;
  bit m_loop = 0;
  logic [DW-1:0] m_sample = '0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  // what the sequencer must do at the coming edge, from the playback rules alone
  task automatic model_edge();
    int a;
    case (m_mode)
      0: if (bus.start) begin
        m_div = int'(bus.cfg_div); m_len = int'(bus.cfg_len); m_loop = bus.cfg_loop;
        active = 0; n = 0; m_addr = 0; last_due = 0; m_mode = 1;
      end
      1: if (bus.stop) m_mode = 2;
      else if (!bus.hold) begin
        active++;
        if (active % (m_div + 1) == 0) begin
          a = m_loop ? n % (m_len + 1) : n;
          q.push_back('{due: cyc + RL + 1, val: mem[a]});
          last_due = cyc + RL + 1;
          n++;
          m_addr = m_loop ? n % (m_len + 1) : (n > m_len ? m_len : n);
          if (!m_loop && n == m_len + 1) m_mode = 2;
        end
      end
      default: if (cyc >= last_due) begin m_mode = 0; done_at = cyc + 1; end
    endcase
  endtask
  task automatic check_outputs();
    logic ev;
    ev = q.size() > 0 && q[0].due == cyc;
    if (ev) begin m_sample = q[0].val; void'(q.pop_front()); end
    if (bus.sample_valid) nval++;
    check("sample_valid", bus.sample_valid, ev);
    check("sample", bus.sample, m_sample);
    check("busy", bus.busy, m_mode != 0);
    check("done", bus.done, done_at == cyc);
    check("rom_addr", bus.rom_addr, m_addr);
  endtask
  task automatic step(input logic st, input logic sp, input logic hd);
    bus.start = st; bus.stop = sp; bus.hold = hd;
    model_edge();
    @(posedge sys_clk); cyc++;
    @(negedge sys_clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.cfg_div = DV'($urandom); bus.cfg_len = AW'($urandom); bus.cfg_loop = 1'($urandom);
    check_outputs();
  endtask
  task automatic start_run(input int d, input int l, input bit lp);
    bus.cfg_div = DV'(d); bus.cfg_len = AW'(l); bus.cfg_loop = lp;
    nval = 0;
    step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic run_until_idle();
    for (int i = 0; i < 3000 && (bus.busy || m_mode != 0); i++) step(1'b0, 1'b0, 1'b0);
    check("reach_idle", bus.busy, 1'b0);
  endtask
  task automatic reset_now();
    #2 sys_rst = 1'b1;
    #1;
    check("rst_valid", bus.sample_valid, 1'b0);
    check("rst_sample", bus.sample, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_addr", bus.rom_addr, '0);
    q.delete(); m_mode = 0; m_sample = '0; m_addr = 0; done_at = -1;
    @(posedge sys_clk); cyc++;
    @(negedge sys_clk); sys_rst = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
    bus.cfg_div = '0; bus.cfg_len = '0; bus.cfg_loop = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    #1;
    check("init_valid", bus.sample_valid, 1'b0);
    check("init_busy", bus.busy, 1'b0);
    check("init_addr", bus.rom_addr, '0);
    @(negedge sys_clk); sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    // one-shot, one sample per clock
    start_run(0, 7, 1'b0);
    run_until_idle();
    check("oneshot_count", nval, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    // looping with period 5; stop arriving mid-run
    start_run(4, 3, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_until_idle();
    check("loop_count", nval, 8);
    // stop after the sixth issue, with an ignored start during drain
    start_run(int'($urandom_range(0, 2)), 3, 1'b1);
    for (int i = 0; i < 100 && !(m_mode == 1 && n == 6); i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_until_idle();
    check("stop6_count", nval, 6);
    // hold window mid-run
    start_run(2, 15, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    run_until_idle();
    check("hold_count", nval, 16);
    // asynchronous reset with reads in flight
    start_run(0, 20, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    reset_now();
    nval = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    check("post_rst_count", nval, 0);
    // stop coinciding with the one-shot final tick
    start_run(0, 5, 1'b0);
    for (int i = 0; i < 50 && !(m_mode == 1 && n == 5); i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_until_idle();
    check("stop_final_count", nval, 5);
    // cfg_len=0 in both modes
    start_run(1, 0, 1'b0);
    run_until_idle();
    check("len0_oneshot_count", nval, 1);
    start_run(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_until_idle();
    // random configurations with random hold/stop traffic
    for (int r = 0; r < 6; r++) begin
      start_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'($urandom));
      for (int i = 0; i < 60; i++)
        step(1'b0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      step(1'b0, 1'b1, 1'b0);
      run_until_idle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rom_sample_sequencer.md
Name: rom_sample_sequencer

Overview:
- Drives the address port of the 12-bit test-signal block ROM and turns the ROM output into a paced sample stream (sample + valid) for the downstream FIR datapath.
- Supports a programmable sample period, a programmable playback length, one-shot or loop mode, start/stop/hold control, and compensation for the ROM read latency.
- Sits between the ROM instance and the filter input.

Parameters:
- ADDR_W, 10: ROM address width.
- DATA_W, 12: ROM/sample data width.
- RD_LAT, 2: ROM read latency in clocks (address register edge to valid rom_data), range 1..4.
- DIV_W, 16: sample-period divider width.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; latches cfg_* and begins playback (ignored unless IDLE).
- stop  in  1  single-cycle pulse; ends playback after in-flight reads drain.
- hold  in  1  level; freezes divider and issue while high.
- cfg_div  in  DIV_W  sample period minus 1 (0 = one sample per clock).
- cfg_len  in  ADDR_W  last address played (length minus 1).
- cfg_loop  in  1  1 = wrap to address 0 after cfg_len; 0 = one-shot.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data.
- sample  out  DATA_W  registered output sample.
- sample_valid  out  1  one-cycle strobe per sample.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Reset (asynchronous, any state): FSM=IDLE; rom_addr=0; sample=0; sample_valid=0; busy=0; done=0; divider=0; issue pipe cleared; latched config=0. In-flight reads are discarded and produce no sample_valid.
- States: IDLE, RUN, DRAIN.
- IDLE: on start, latch cfg_div/cfg_len/cfg_loop, clear the divider, set rom_addr=0, go to RUN. start in any other state is ignored.
- Tick generation in RUN with hold=0: the divider counts 0..div_l. tick=1 on the cycle the divider equals div_l; the divider then returns to 0. The first tick occurs div_l+1 cycles after entering RUN. While hold=1, the divider and issue are frozen, and the pipe continues to drain.
- Issue: on tick, issue_pipe[0] is set for the current rom_addr. On the same edge, rom_addr advances:
  - to rom_addr+1 if rom_addr<len_l;
  - else to 0 if loop_l=1;
  - else (one-shot at len_l) rom_addr holds and the FSM goes to DRAIN.
- Latency: issue_pipe is an RD_LAT-bit shift register. When its last stage is 1, rom_data is captured into sample on the next edge and sample_valid=1 for exactly that one cycle. An issue at cycle t yields sample_valid at cycle t+RD_LAT+1. sample holds its value between strobes.
- stop in RUN: no further issue (including any tick in the same cycle as stop); go to DRAIN.
- stop in DRAIN or IDLE: ignored.
- DRAIN: wait until issue_pipe is all-zero, then go to IDLE with done=1 for one cycle. busy drops in the same cycle done rises. rom_addr is left at its last value.
- stop and a one-shot final tick in the same cycle: the final tick is suppressed (stop wins), so exactly len_l samples are delivered (addresses 0..len_l-1).
- Config changes while busy have no effect until the next start.
- cfg_len=0: one-shot plays the single address 0; loop mode repeats address 0.

Test Plan:
- RD_LAT=2, cfg_div=0, cfg_len=7, cfg_loop=0, start at cycle 0 -> rom_addr steps 0..7 one per clock; sample_valid high 8 consecutive cycles starting 4 cycles after start; samples equal ROM words 0..7; done one cycle after the last valid; busy=0 afterwards.
- cfg_div=4, cfg_len=3, cfg_loop=1 -> sample_valid every 5 cycles; address sequence 0,1,2,3,0,1,...; no done while running.
- Loop mode, stop asserted after the 6th issue -> exactly 6 samples total; done after the pipe drains; a start pulse during DRAIN is ignored.
- hold high for 10 cycles mid-run with cfg_div=2 -> no issues during hold, in-flight samples still delivered, divider resumes from its frozen count.
- sys_rst asserted with 2 reads in flight -> all outputs 0 immediately, no sample_valid after deassert, FSM IDLE.
- One-shot cfg_len=5 with stop coinciding with the final tick -> 5 samples (ROM words 0..4), then done.
